bit_serializer: RTL and testbench
=================================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8, sets the parallel word width in bits (legal range 2..32).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 in_data  input  WIDTH  parallel word offered by the producer.
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_ready  output  1  block can accept a word this cycle; a transfer occurs when in_valid and in_ready are both 1 at a rising edge.
REQ-007 stall  input  1  downstream hold request; freezes serialisation while 1.
REQ-008 x  output  1  serial bit stream driven into the ones-counting FSM.
REQ-009 x_valid  output  1  x carries a data bit this cycle.
REQ-010 sow  output  1  start-of-word marker, 1 with the MSB of each word.
REQ-011 eow  output  1  end-of-word marker, 1 with the LSB of each word.

Function
REQ-012 The block SHALL contain a WIDTH-bit shift register, a bit counter and a one-entry holding buffer, controlled by a two-state FSM: IDLE (shifter empty) and SHIFT (shifter loaded).
REQ-013 Words SHALL be serialised MSB first, one bit per unstalled cycle, WIDTH cycles per word.
REQ-014 x, x_valid, sow and eow SHALL all be registered outputs.
REQ-015 Bit 0 of an output cycle SHALL carry the MSB of a word accepted at the preceding edge when the shifter is free, giving one-cycle latency from acceptance.
REQ-016 In IDLE, or in SHIFT while emitting the last bit unstalled, with the buffer empty, an accepted word SHALL load directly into the shifter; otherwise it SHALL load into the buffer.
REQ-017 When the last bit is emitted unstalled and the buffer is full, the buffer word SHALL move to the shifter at that edge, giving back-to-back words with zero gap cycles.
REQ-018 in_ready SHALL equal NOT buffer_full; it SHALL NOT depend combinationally on in_valid or stall.
REQ-019 When the last bit is emitted with both the buffer and the input empty, the FSM SHALL return to IDLE.
REQ-020 While x_valid is 0, x, sow and eow SHALL be driven 0, so the downstream ones-counter state is unaffected by idle cycles.
REQ-021 While stall is 1, the shifter, the counter and the FSM SHALL hold.
REQ-022 During stall, the x_valid, x, sow and eow registers SHALL be 0 at the next edge.
REQ-023 A word SHALL still be accepted into the buffer during stall if in_ready is 1.
REQ-024 Stall asserted on the last bit SHALL delay the eow cycle; no bit SHALL ever be dropped or duplicated.
REQ-025 in_data SHALL be sampled only on a transfer edge; changes to it at other times SHALL have no effect.

Reset
REQ-026 With reset_n 0 at a rising edge, the FSM SHALL go to IDLE and the buffer SHALL be empty.
REQ-027 Reset SHALL set x, x_valid, sow and eow to 0, and in_ready to 1 from the following cycle.
REQ-028 Reset mid-word SHALL discard the partial word and any buffered word; no further bits of either SHALL appear.
REQ-029 reset_n SHALL override stall and in_valid.

Structure
REQ-030 The FSM state encoding (IDLE, SHIFT) and the default WIDTH constant SHALL live in a shared package, for reuse by the downstream counter testbench.
REQ-031 The holding buffer SHALL be a sub-module named skid_reg1 with a valid/ready handshake on both sides; the remaining logic SHALL stay flat.

Verification
REQ-032 Reset, then a single word 0xB5 with WIDTH=8 -> x = 1,0,1,1,0,1,0,1 on 8 consecutive cycles starting the cycle after acceptance; sow on the 1st, eow on the 8th; the downstream FSM ends in S2 (5 ones, 5 mod 3 = 2).
REQ-033 Continuous in_valid with words 0xFF then 0x00 -> 16 contiguous x_valid cycles; in_ready low only while the buffer is full; no gap between eow and the next sow.
REQ-034 Word 0xA0 with stall held high for 3 cycles after the 2nd bit -> x_valid low for exactly 3 cycles; remaining bits 1,0,0,0,0,0 follow intact; eow 3 cycles later than unstalled.
REQ-035 reset_n pulsed low after the 4th bit of 0x0F, with 0x33 buffered -> x_valid 0 from the next cycle; in_ready 1; neither word's remaining bits appear.
REQ-036 Stall held high while two words are offered -> the first word is accepted into the buffer, in_ready drops, the second is held off; after release both words serialise in order.
REQ-037 Randomised words and stalls against a reference queue -> the bit stream matches the queue exactly and x is 0 whenever x_valid is 0.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer and its downstream users.
// Holds the FSM state encoding and the default parallel word width.
package bit_serializer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // IDLE: shifter holds no bits still to send; SHIFT: shifter holds pending bits.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage : bit_serializer_pkg

// File: rtl/bit_serializer_skid_reg1.sv
// One-entry holding buffer with valid/ready handshakes on both sides.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   in_data/in_valid    word offered for storage
//   in_ready            buffer is empty and can take a word
//   out_data/out_valid  stored word and its valid flag
//   out_ready           consumer takes the stored word this edge
module skid_reg1
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Storage register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // Push only when empty, so push and pop never coincide.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  assign in_ready  = ~valid_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule : skid_reg1

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter feeding a ones-counting FSM, MSB first.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   in_data/in_valid    parallel word offered by the producer
//   in_ready            a word can be accepted (holding buffer empty)
//   stall               downstream hold; freezes serialisation
//   x, x_valid          serial bit and its qualifier (registered)
//   sow, eow            start/end-of-word markers (registered)
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stall,
  output logic             x,
  output logic             x_valid,
  output logic             sow,
  output logic             eow
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             sow_q, sow_d;
  logic             eow_q, eow_d;

  logic [WIDTH-1:0] buf_data;
  logic             buf_valid;
  logic             accept_c;
  logic             last_c;
  logic             free_c;
  logic             load_c;
  logic             buf_push_c;
  logic [WIDTH-1:0] new_word_c;

  // cnt_q counts bits still to emit; the final bit goes out when it is 1.
  assign accept_c   = in_valid & in_ready;
  assign last_c     = (state_q == SHIFT) && (cnt_q == CNT_W'(1));
  assign free_c     = ~stall & ((state_q == IDLE) | last_c);
  assign load_c     = free_c & (buf_valid | accept_c);
  assign buf_push_c = accept_c & ~free_c;
  // Buffer full implies in_ready low, so the buffer always has priority.
  assign new_word_c = buf_valid ? buf_data : in_data;

  skid_reg1 #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  (in_data),
    .in_valid (buf_push_c),
    .in_ready (in_ready),
    .out_data (buf_data),
    .out_valid(buf_valid),
    .out_ready(free_c)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      sow_q     <= 1'b0;
      eow_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      sow_q     <= sow_d;
      eow_q     <= eow_d;
    end
  end

  // Next state and next outputs; everything holds and outputs go quiet on stall.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    x_d       = 1'b0;
    x_valid_d = 1'b0;
    sow_d     = 1'b0;
    eow_d     = 1'b0;
    if (!stall) begin
      case (state_q)
        IDLE: begin
          // From idle the MSB goes out at the load edge for one-cycle latency.
          if (load_c) begin
            x_d       = new_word_c[WIDTH-1];
            x_valid_d = 1'b1;
            sow_d     = 1'b1;
            shift_d   = {new_word_c[WIDTH-2:0], 1'b0};
            cnt_d     = CNT_W'(WIDTH - 1);
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          x_d       = shift_q[WIDTH-1];
          x_valid_d = 1'b1;
          sow_d     = (cnt_q == CNT_W'(WIDTH));
          eow_d     = last_c;
          shift_d   = {shift_q[WIDTH-2:0], 1'b0};
          cnt_d     = cnt_q - CNT_W'(1);
          if (last_c) begin
            // Next word's MSB follows on the next edge with no gap.
            if (load_c) begin
              shift_d = new_word_c;
              cnt_d   = CNT_W'(WIDTH);
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign sow     = sow_q;
  assign eow     = eow_q;

endmodule : bit_serializer

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: directed scenarios plus randomised
// words and stalls, checked bit by bit against an expected-bit queue.
module tb_bit_serializer;
  import bit_serializer_pkg::*;

  localparam int unsigned W = DEFAULT_WIDTH;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         stall;
  logic         x;
  logic         x_valid;
  logic         sow;
  logic         eow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Expected entries: {bit, sow, eow}, pushed in acceptance order.
  logic [2:0] exp_q[$];
  logic [2:0] mon_e;
  bit   mon_en = 1'b0;
  bit   rand_mode = 1'b0;

  int bits_seen = 0;
  int ones_mod3 = 0;
  int sow_cyc = 0;
  int eow_cyc = 0;
  int gap = 0;
  int last_gap = 0;
  int run_len = 0;
  int last_run = 0;
  bit in_word = 1'b0;

  bit_serializer #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .stall   (stall),
    .x       (x),
    .x_valid (x_valid),
    .sow     (sow),
    .eow     (eow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expected entry per valid output bit.
  always @(negedge clk) begin
    if (mon_en) begin
      if (x_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bit: got x=%0b expected no bit (cycle %0d)", x, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("bit_sow_eow", 32'({x, sow, eow}), 32'(mon_e));
        end
        bits_seen++;
        if (x) ones_mod3 = (ones_mod3 + 1) % 3;
        run_len++;
        if (sow) begin
          sow_cyc = cyc;
          gap = 0;
          in_word = 1'b1;
        end
        if (eow) begin
          eow_cyc = cyc;
          last_gap = gap;
          in_word = 1'b0;
        end
      end else begin
        chk("idle_quiet", 32'({x, sow, eow}), 32'd0);
        if (run_len > 0) last_run = run_len;
        run_len = 0;
        if (in_word) gap++;
      end
      if (!reset_n) begin
        exp_q.delete();
        in_word = 1'b0;
      end
    end
  end

  task automatic tick();
    if (rand_mode) stall = ($urandom_range(0, 3) == 0);
    @(negedge clk);
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_data  = W'($urandom);
  endtask

  // Offer a word; returns at the negedge after the transfer edge.
  task automatic offer(input logic [W-1:0] w, output int acc);
    int n = 0;
    acc = -1;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL offer_timeout: got in_ready=0 expected 1 within 200 cycles");
      idle_in();
    end else begin
      acc = cyc + 1;
      for (int i = int'(W) - 1; i >= 0; i--)
        exp_q.push_back({w[i], logic'(i == int'(W) - 1), logic'(i == 0)});
      tick();
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int a0, a1, base, low, seen;
    logic [W-1:0] w;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    stall    = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    chk("reset_outputs", 32'({x_valid, x, sow, eow}), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // Single word 0xB5: latency, span and ones count.
    base = ones_mod3;
    offer(8'hB5, a0);
    idle_in();
    drain();
    chk("b5_sow_cycle", 32'(sow_cyc), 32'(a0));
    chk("b5_eow_cycle", 32'(eow_cyc), 32'(a0 + 7));
    chk("b5_run_len", 32'(last_run), 32'd8);
    chk("b5_ones_mod3", 32'(ones_mod3), 32'((base + $countones(8'hB5)) % 3));

    // Back-to-back 0xFF, 0x00.
    offer(8'hFF, a0);
    offer(8'h00, a1);
    idle_in();
    low = 0;
    for (int i = 0; i < 20; i++) begin
      if (!in_ready) low++;
      tick();
    end
    chk("b2b_ready_low_cycles", 32'(low), 32'(W - 2));
    drain();
    chk("b2b_run_len", 32'(last_run), 32'(2 * W));
    chk("b2b_eow_cycle", 32'(eow_cyc), 32'(a0 + 15));

    // 0xA0 with a 3-cycle stall after the 2nd bit.
    offer(8'hA0, a0);
    idle_in();
    tick();
    stall = 1'b1;
    tick();
    tick();
    tick();
    stall = 1'b0;
    drain();
    chk("stall_gap", 32'(last_gap), 32'd3);
    chk("stall_eow_cycle", 32'(eow_cyc), 32'(a0 + 10));

    // Reset after the 4th bit of 0x0F with 0x33 buffered.
    offer(8'h0F, a0);
    offer(8'h33, a1);
    idle_in();
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    chk("rst_x_valid", 32'(x_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    seen = bits_seen;
    tick();
    reset_n = 1'b1;
    repeat (12) tick();
    chk("rst_no_more_bits", 32'(bits_seen), 32'(seen));
    chk("rst_queue_flushed", 32'(exp_q.size()), 32'd0);

    // Stall held while two words are offered.
    stall = 1'b1;
    offer(8'hC3, a0);
    chk("stall_buf_full", 32'(in_ready), 32'd0);
    in_data  = 8'h3C;
    in_valid = 1'b1;
    low = 0;
    for (int i = 0; i < 4; i++) begin
      if (!in_ready) low++;
      chk("stall_no_output", 32'(x_valid), 32'd0);
      tick();
    end
    chk("stall_held_off", 32'(low), 32'd4);
    stall = 1'b0;
    offer(8'h3C, a1);
    idle_in();
    drain();

    // Randomised words, gaps and stalls.
    rand_mode = 1'b1;
    for (int k = 0; k < 40; k++) begin
      w = W'($urandom);
      offer(w, a0);
      if ($urandom_range(0, 1) == 1) begin
        idle_in();
        repeat ($urandom_range(0, 3)) tick();
      end
    end
    idle_in();
    rand_mode = 1'b0;
    stall = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_bit_serializer
